// File: rtl/dump_mem_datos_tx.sv
// ----------------------------------------------------------------------------
// dump_mem_datos_tx
// Upload path of the debug link. On i_start it walks the whole data memory
// and, for every dirty word (or every word when DUMP_ALL=1), sends a 6-byte
// frame [addr_hi, addr_lo, d3, d2, d1, d0] through the UART transmitter. The
// dump ends with the marker 0xFF 0xFF followed by a one-cycle o_done.
//
// Ports
//   i_clock       system clock
//   i_reset       asynchronous, active-high reset
//   i_start       1-cycle pulse: begin dump (ignored while o_busy=1)
//   i_dato_mem    memory read data, valid 1 cycle after o_addr_mem
//   i_bit_sucio   dirty bit of o_addr_mem, valid 1 cycle after o_addr_mem
//   i_tx_done     1-cycle pulse from tx: current byte fully sent
//   o_addr_mem    read address to data memory and dirty-bit control
//   o_tx_start    1-cycle pulse: tx loads o_data_tx
//   o_data_tx     byte to transmit, stable from o_tx_start until i_tx_done
//   o_busy        dump in progress
//   o_done        1-cycle pulse after the last marker byte is sent
//   o_word_count  words sent in the current/last dump (marker not counted)
// ----------------------------------------------------------------------------
module dump_mem_datos_tx #(
    parameter int ADDR_MEM_DATOS_LENGTH = 10,
    parameter int RAM_WIDTH_DATOS       = 32,
    parameter int WIDTH_WORD            = 8,
    parameter bit DUMP_ALL              = 1'b0
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [RAM_WIDTH_DATOS-1:0]       i_dato_mem,
    input  logic                             i_bit_sucio,
    input  logic                             i_tx_done,
    output logic [ADDR_MEM_DATOS_LENGTH-1:0] o_addr_mem,
    output logic                             o_tx_start,
    output logic [WIDTH_WORD-1:0]            o_data_tx,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [ADDR_MEM_DATOS_LENGTH:0]   o_word_count
);

    localparam int AW = ADDR_MEM_DATOS_LENGTH;
    localparam int W  = WIDTH_WORD;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_READ, ST_LATCH, ST_SEND, ST_WAIT,
        ST_NEXT, ST_MARK, ST_MWAIT, ST_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [AW-1:0]          r_addr;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_next;
    logic [RAM_WIDTH_DATOS-1:0] r_word;
    logic [RAM_WIDTH_DATOS-1:0] w_word_src;
    logic [AW:0]            r_word_count;
    logic [W-1:0]           r_data_tx;
    logic [W-1:0]           w_byte_sel;
    logic [2*W-1:0]         w_addr_ext;

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_READ;
            ST_READ:  w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = (i_bit_sucio || DUMP_ALL) ? ST_SEND : ST_NEXT;
            ST_SEND:  w_state_next = ST_WAIT;
            ST_WAIT:  if (i_tx_done) w_state_next = (r_idx == 3'd5) ? ST_NEXT : ST_SEND;
            ST_NEXT:  w_state_next = (r_addr == LAST_ADDR) ? ST_MARK : ST_READ;
            ST_MARK:  w_state_next = ST_MWAIT;
            ST_MWAIT: if (i_tx_done) w_state_next = (r_idx == 3'd1) ? ST_DONE : ST_MARK;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_tx_start = (r_state == ST_SEND) || (r_state == ST_MARK);
        o_busy     = (r_state != ST_IDLE);
        o_done     = (r_state == ST_DONE);
    end

    // Byte index: cleared on LATCH (frame) and NEXT (marker), advanced per handshake
    always_comb begin
        w_idx_next = r_idx;
        case (r_state)
            ST_LATCH, ST_NEXT: w_idx_next = '0;
            ST_WAIT, ST_MWAIT: if (i_tx_done) w_idx_next = r_idx + 3'd1;
            default: ;
        endcase
    end

    // The byte is registered on the edge entering SEND/MARK, so the first
    // frame byte must be chosen from the word being latched in this cycle.
    always_comb begin
        w_word_src = (r_state == ST_LATCH) ? i_dato_mem : r_word;
        w_addr_ext = '0;
        w_addr_ext[AW-1:0] = r_addr;
        case (w_idx_next)
            3'd0:    w_byte_sel = w_addr_ext[2*W-1:W];
            3'd1:    w_byte_sel = w_addr_ext[W-1:0];
            3'd2:    w_byte_sel = w_word_src[4*W-1 -: W];
            3'd3:    w_byte_sel = w_word_src[3*W-1 -: W];
            3'd4:    w_byte_sel = w_word_src[2*W-1 -: W];
            3'd5:    w_byte_sel = w_word_src[W-1:0];
            default: w_byte_sel = '0;
        endcase
        if (w_state_next == ST_MARK) w_byte_sel = '1;
    end

    // Datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr       <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_word_count <= '0;
            r_data_tx    <= '0;
        end else begin
            r_idx <= w_idx_next;
            if (r_state == ST_IDLE && i_start) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end
            if (r_state == ST_LATCH)
                r_word <= i_dato_mem;
            if (r_state == ST_WAIT && i_tx_done && r_idx == 3'd5)
                r_word_count <= r_word_count + (AW+1)'(1);
            if (r_state == ST_NEXT && r_addr != LAST_ADDR)
                r_addr <= r_addr + AW'(1);
            if (w_state_next == ST_SEND || w_state_next == ST_MARK)
                r_data_tx <= w_byte_sel;
        end
    end

    assign o_addr_mem   = r_addr;
    assign o_data_tx    = r_data_tx;
    assign o_word_count = r_word_count;

endmodule
